// File: rtl/sfr_access_ctrl.sv
// Two-port arbiter/sequencer for SFR direct-address accesses.
// Each transaction runs IDLE -> ISSUE -> CAPTURE -> RESP; state is exported on dbg_state_o.
module sfr_access_ctrl #(
   parameter int PRIO_MODE = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       we0,
   input  logic       Bb0,
   input  logic [7:0] addr0,
   input  logic [2:0] pos0,
   input  logic [7:0] data0,
   input  logic       bit0,
   output logic       ack0,
   output logic       err0,
   output logic [7:0] rdata0,
   output logic       rbit0,
   input  logic       req1,
   input  logic       we1,
   input  logic       Bb1,
   input  logic [7:0] addr1,
   input  logic [2:0] pos1,
   input  logic [7:0] data1,
   input  logic       bit1,
   output logic       ack1,
   output logic       err1,
   output logic [7:0] rdata1,
   output logic       rbit1,
   output logic       busy,
   output logic [7:0] sfr_addr,
   output logic       sfr_en,
   output logic       sfr_oe,
   output logic       sfr_Bb,
   output logic [7:0] sfr_pos,
   output logic [7:0] sfr_din,
   output logic       sfr_bin,
   input  logic [7:0] sfr_dout,
   input  logic       sfr_bout,
   output logic [1:0] dbg_state_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t     state_q, state_d;
   logic       gnt_q, gnt_d;
   logic       last_q, last_d;
   logic       we_q, we_d;
   logic       bb_q, bb_d;
   logic [7:0] addr_q, addr_d;
   logic [2:0] pos_q, pos_d;
   logic [7:0] data_q, data_d;
   logic       bit_q, bit_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rbit_q, rbit_d;

   logic sel;
   logic valid;
   logic rd;

   // On a tie, round-robin favours whoever was not served last.
   assign sel   = (req0 & req1) ? ((PRIO_MODE == 1) ? 1'b0 : ~last_q) : req1;
   assign valid = addr_q[7];
   assign rd    = valid & ~we_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         bb_q    <= 1'b0;
         addr_q  <= 8'h00;
         pos_q   <= 3'd0;
         data_q  <= 8'h00;
         bit_q   <= 1'b0;
         rdata_q <= 8'h00;
         rbit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         we_q    <= we_d;
         bb_q    <= bb_d;
         addr_q  <= addr_d;
         pos_q   <= pos_d;
         data_q  <= data_d;
         bit_q   <= bit_d;
         rdata_q <= rdata_d;
         rbit_q  <= rbit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      we_d    = we_q;
      bb_d    = bb_q;
      addr_d  = addr_q;
      pos_d   = pos_q;
      data_d  = data_q;
      bit_d   = bit_q;
      rdata_d = rdata_q;
      rbit_d  = rbit_q;
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = ISSUE;
               gnt_d   = sel;
               last_d  = sel;
               we_d    = sel ? we1   : we0;
               bb_d    = sel ? Bb1   : Bb0;
               addr_d  = sel ? addr1 : addr0;
               pos_d   = sel ? pos1  : pos0;
               data_d  = sel ? data1 : data0;
               bit_d   = sel ? bit1  : bit0;
            end
         end
         ISSUE:   state_d = CAPTURE;
         CAPTURE: begin
            state_d = RESP;
            rdata_d = (rd & bb_q)  ? sfr_dout : 8'h00;
            rbit_d  = (rd & ~bb_q) ? sfr_bout : 1'b0;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack0     = 1'b0;
      err0     = 1'b0;
      rdata0   = 8'h00;
      rbit0    = 1'b0;
      ack1     = 1'b0;
      err1     = 1'b0;
      rdata1   = 8'h00;
      rbit1    = 1'b0;
      sfr_addr = 8'h00;
      sfr_en   = 1'b0;
      sfr_oe   = 1'b0;
      sfr_Bb   = 1'b0;
      sfr_pos  = 8'h00;
      sfr_din  = 8'h00;
      sfr_bin  = 1'b0;
      case (state_q)
         ISSUE: begin
            sfr_addr = addr_q;
            sfr_Bb   = bb_q;
            sfr_pos  = 8'h01 << pos_q;
            sfr_din  = data_q;
            sfr_bin  = bit_q;
            sfr_en   = valid & we_q;
            sfr_oe   = rd;
         end
         CAPTURE: begin
            // Reads keep the SFR addressed so its falling-edge data is stable here.
            if (rd) begin
               sfr_addr = addr_q;
               sfr_Bb   = bb_q;
               sfr_oe   = 1'b1;
            end
         end
         RESP: begin
            if (gnt_q) begin
               ack1   = 1'b1;
               err1   = ~valid;
               rdata1 = rdata_q;
               rbit1  = rbit_q;
            end else begin
               ack0   = 1'b1;
               err0   = ~valid;
               rdata0 = rdata_q;
               rbit0  = rbit_q;
            end
         end
         default: ;
      endcase
   end

   assign busy        = (state_q != IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sfr_access_ctrl.sv
// Bench for sfr_access_ctrl: SFR memory model, scoreboard of expected responses,
// directed cases (write, bit read, tie arbitration, out-of-range, reset mid-transaction) plus random traffic.
module tb_sfr_access_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, we0, Bb0, bit0;
   logic [7:0] addr0, data0;
   logic [2:0] pos0;
   logic       req1, we1, Bb1, bit1;
   logic [7:0] addr1, data1;
   logic [2:0] pos1;
   logic       ack0, err0, rbit0, ack1, err1, rbit1;
   logic [7:0] rdata0, rdata1;
   logic       busy, sfr_en, sfr_oe, sfr_Bb, sfr_bin;
   logic [7:0] sfr_addr, sfr_pos, sfr_din;
   logic [7:0] sfr_dout;
   logic       sfr_bout;
   logic [1:0] dbg_state;

   // Second instance in fixed-priority mode, sharing the request inputs.
   logic       b_ack0, b_err0, b_rbit0, b_ack1, b_err1, b_rbit1;
   logic [7:0] b_rdata0, b_rdata1;
   logic       b_busy, b_en, b_oe, b_Bb, b_bin;
   logic [7:0] b_addr, b_pos, b_din;
   logic [1:0] b_state;

   int errors = 0;
   int checks = 0;
   logic [10:0] exp_q[$];   // {id, err, rdata[7:0], rbit}
   logic [7:0]  ref_mem[128];
   int cyc = 0;
   int en_cnt = 0;
   logic [7:0] last_din = 8'h00;
   logic [7:0] last_pos = 8'h00;

   always #5 clk = ~clk;

   sfr_access_ctrl #(.PRIO_MODE(0)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .Bb0(Bb0), .addr0(addr0), .pos0(pos0), .data0(data0), .bit0(bit0),
      .ack0(ack0), .err0(err0), .rdata0(rdata0), .rbit0(rbit0),
      .req1(req1), .we1(we1), .Bb1(Bb1), .addr1(addr1), .pos1(pos1), .data1(data1), .bit1(bit1),
      .ack1(ack1), .err1(err1), .rdata1(rdata1), .rbit1(rbit1),
      .busy(busy), .sfr_addr(sfr_addr), .sfr_en(sfr_en), .sfr_oe(sfr_oe), .sfr_Bb(sfr_Bb),
      .sfr_pos(sfr_pos), .sfr_din(sfr_din), .sfr_bin(sfr_bin),
      .sfr_dout(sfr_dout), .sfr_bout(sfr_bout), .dbg_state_o(dbg_state)
   );

   sfr_access_ctrl #(.PRIO_MODE(1)) dut_fixed (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .Bb0(Bb0), .addr0(addr0), .pos0(pos0), .data0(data0), .bit0(bit0),
      .ack0(b_ack0), .err0(b_err0), .rdata0(b_rdata0), .rbit0(b_rbit0),
      .req1(req1), .we1(we1), .Bb1(Bb1), .addr1(addr1), .pos1(pos1), .data1(data1), .bit1(bit1),
      .ack1(b_ack1), .err1(b_err1), .rdata1(b_rdata1), .rbit1(b_rbit1),
      .busy(b_busy), .sfr_addr(b_addr), .sfr_en(b_en), .sfr_oe(b_oe), .sfr_Bb(b_Bb),
      .sfr_pos(b_pos), .sfr_din(b_din), .sfr_bin(b_bin),
      .sfr_dout(sfr_dout), .sfr_bout(sfr_bout), .dbg_state_o(b_state)
   );

   function automatic logic [7:0] init_val(input int i);
      return 8'((i * 37 + 11) ^ 8'h5C);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // SFR model: writes and read data update on the falling edge.
   initial begin
      logic [7:0] mem[128];
      logic [7:0] pos_l;
      pos_l = 8'h00;
      sfr_dout = 8'h00;
      sfr_bout = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = init_val(i);
      forever begin
         @(negedge clk);
         if (sfr_en) begin
            if (sfr_Bb) mem[sfr_addr[6:0]] = sfr_din;
            else mem[sfr_addr[6:0]] = (mem[sfr_addr[6:0]] & ~sfr_pos) | (sfr_bin ? sfr_pos : 8'h00);
         end
         if (sfr_pos != 8'h00) pos_l = sfr_pos;
         if (sfr_oe) begin
            sfr_dout = mem[sfr_addr[6:0]];
            sfr_bout = |(mem[sfr_addr[6:0]] & pos_l);
         end
      end
   end

   // Monitor and scoreboard pop.
   always @(negedge clk) begin
      logic [10:0] obs;
      cyc++;
      if (sfr_en) begin
         en_cnt++;
         last_din = sfr_din;
         check_eq("en_addr_range", {31'd0, sfr_addr[7]}, 32'd1);
      end
      if (sfr_pos != 8'h00) last_pos = sfr_pos;
      if (ack0 && ack1) check_eq("dual_ack", 32'd1, 32'd0);
      else if (ack0 || ack1) begin
         obs = ack1 ? {1'b1, err1, rdata1, rbit1} : {1'b0, err0, rdata0, rbit0};
         if (ack1) check_eq("other_side0", {22'd0, err0, rdata0, rbit0}, 32'd0);
         else check_eq("other_side1", {22'd0, err1, rdata1, rbit1}, 32'd0);
         if (exp_q.size() == 0) check_eq("unexpected_ack", {21'd0, obs}, 32'h7FF);
         else check_eq("resp", {21'd0, obs}, {21'd0, exp_q.pop_front()});
      end
   end

   task automatic set_inputs(input bit id, input logic we, input logic bb, input logic [7:0] addr,
                             input logic [2:0] pos, input logic [7:0] data, input logic b);
      if (id) begin
         we1 = we; Bb1 = bb; addr1 = addr; pos1 = pos; data1 = data; bit1 = b;
      end else begin
         we0 = we; Bb0 = bb; addr0 = addr; pos0 = pos; data0 = data; bit0 = b;
      end
   endtask

   function automatic logic [10:0] expect_resp(input bit id, input logic we, input logic bb,
                                               input logic [7:0] addr, input logic [2:0] pos,
                                               input logic [7:0] data, input logic b);
      logic [7:0] v;
      if (!addr[7]) return {id, 1'b1, 8'h00, 1'b0};
      v = ref_mem[addr[6:0]];
      if (we) begin
         if (bb) ref_mem[addr[6:0]] = data;
         else ref_mem[addr[6:0]][pos] = b;
         return {id, 1'b0, 8'h00, 1'b0};
      end
      if (bb) return {id, 1'b0, v, 1'b0};
      return {id, 1'b0, 8'h00, v[pos]};
   endfunction

   // One transaction from an idle DUT; returns negedges from request to ack.
   task automatic do_txn(input bit id, input logic we, input logic bb, input logic [7:0] addr,
                         input logic [2:0] pos, input logic [7:0] data, input logic b,
                         input bit drop_early, output int lat);
      bit got;
      exp_q.push_back(expect_resp(id, we, bb, addr, pos, data, b));
      @(posedge clk);
      #1;
      set_inputs(id, we, bb, addr, pos, data, b);
      if (id) req1 = 1'b1; else req0 = 1'b1;
      got = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (i == 2) begin
            // Already latched: scrambling the inputs must not matter.
            set_inputs(id, 1'($urandom), 1'($urandom), 8'($urandom), 3'($urandom), 8'($urandom), 1'($urandom));
            if (drop_early) begin
               if (id) req1 = 1'b0; else req0 = 1'b0;
            end
         end
         if (id ? ack1 : ack0) begin
            got = 1'b1;
            lat = i;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      check_eq("ack_seen", {31'd0, got}, 32'd1);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, exp_q=%0d", exp_q.size());
      $fatal(1);
   end

   initial begin
      int lat, e0, n, prev, b0, b1;
      for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      set_inputs(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
      set_inputs(1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
      check_eq("rst_sfr", {5'd0, sfr_addr, sfr_en, sfr_oe, sfr_Bb, sfr_pos, sfr_din, sfr_bin}, 32'd0);
      check_eq("rst_ack", {30'd0, ack0, ack1}, 32'd0);
      reset = 1'b0;

      // Byte write from requester 0.
      e0 = en_cnt;
      do_txn(1'b0, 1'b1, 1'b1, 8'hA8, 3'd0, 8'h5A, 1'b0, 1'b0, lat);
      check_eq("wr_latency", lat, 4);
      check_eq("wr_en_cycles", en_cnt - e0, 1);
      check_eq("wr_din", {24'd0, last_din}, 32'h5A);

      // Bit read from requester 1 (model bit 7 of 0xD0 is 1).
      e0 = en_cnt;
      do_txn(1'b1, 1'b0, 1'b0, 8'hD0, 3'd7, 8'h00, 1'b0, 1'b0, lat);
      check_eq("rd_latency", lat, 4);
      check_eq("rd_pos", {24'd0, last_pos}, 32'h80);
      check_eq("rd_no_en", en_cnt - e0, 0);

      // Read back the byte written above.
      do_txn(1'b1, 1'b0, 1'b1, 8'hA8, 3'd0, 8'h00, 1'b0, 1'b0, lat);

      // Out-of-range write.
      e0 = en_cnt;
      do_txn(1'b0, 1'b1, 1'b1, 8'h45, 3'd2, 8'hFF, 1'b1, 1'b0, lat);
      check_eq("oor_no_en", en_cnt - e0, 0);
      check_eq("oor_latency", lat, 4);

      // Request dropped before ack still completes.
      do_txn(1'b1, 1'b1, 1'b0, 8'h90, 3'd4, 8'h00, 1'b1, 1'b1, lat);
      check_eq("drop_latency", lat, 4);

      // Tie arbitration from a fresh reset.
      pulse_reset();
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) exp_q.push_back(expect_resp(1'b0, 1'b0, 1'b1, 8'h84, 3'd0, 8'h00, 1'b0));
         else exp_q.push_back(expect_resp(1'b1, 1'b0, 1'b0, 8'hC1, 3'd3, 8'h00, 1'b0));
      end
      @(posedge clk);
      #1;
      set_inputs(1'b0, 1'b0, 1'b1, 8'h84, 3'd0, 8'h00, 1'b0);
      set_inputs(1'b1, 1'b0, 1'b0, 8'hC1, 3'd3, 8'h00, 1'b0);
      req0 = 1'b1; req1 = 1'b1;
      n = 0; prev = 0; b0 = 0; b1 = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (b_ack0) b0++;
         if (b_ack1) b1++;
         if (ack0 || ack1) begin
            n++;
            if (n > 1) check_eq("tie_gap", cyc - prev, 4);
            prev = cyc;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      check_eq("tie_acks", n, 4);
      check_eq("fixed_ack0", b0, 4);
      check_eq("fixed_ack1", b1, 0);

      // Reset during CAPTURE of a read.
      @(posedge clk);
      #1;
      set_inputs(1'b0, 1'b0, 1'b1, 8'h90, 3'd0, 8'h00, 1'b0);
      req0 = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("capt_state", {30'd0, dbg_state}, 32'd2);
      reset = 1'b1;
      req0 = 1'b0;
      @(negedge clk);
      check_eq("rstc_busy", {31'd0, busy}, 32'd0);
      check_eq("rstc_sfr", {5'd0, sfr_addr, sfr_en, sfr_oe, sfr_Bb, sfr_pos, sfr_din, sfr_bin}, 32'd0);
      check_eq("rstc_ack", {30'd0, ack0, ack1}, 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("rstc_no_ack", {30'd0, ack0, ack1}, 32'd0);
      do_txn(1'b0, 1'b0, 1'b1, 8'hA8, 3'd0, 8'h00, 1'b0, 1'b0, lat);
      check_eq("post_rst_latency", lat, 4);

      // Random traffic, mostly in range.
      for (int t = 0; t < 30; t++) begin
         logic [7:0] a;
         a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 143));
         do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, lat);
         check_eq("rand_latency", lat, 4);
      end

      repeat (4) @(negedge clk);
      check_eq("exp_q_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sfr_access_ctrl.md
SFR_ACCESS_CTRL -- requirements
Module: sfr_access_ctrl

Interface
REQ-001 Parameter PRIO_MODE, default 0: 0 = round-robin between requesters, 1 = fixed priority to requester 0.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising clk edge.
REQ-004 reqN  in  1 (N=0,1)  access request; held high until ackN.
REQ-005 weN  in  1  1 = write, 0 = read.
REQ-006 BbN  in  1  1 = byte access, 0 = bit access.
REQ-007 addrN  in  8  SFR direct address; valid range 0x80-0xFF.
REQ-008 posN  in  3  bit index for bit access.
REQ-009 dataN  in  8  byte write data.
REQ-010 bitN  in  1  bit write data.
REQ-011 ackN  out  1  one-cycle completion pulse.
REQ-012 errN  out  1  valid with ackN; 1 = address out of range, no access performed.
REQ-013 rdataN  out  8  byte read data, valid with ackN.
REQ-014 rbitN  out  1  bit read data, valid with ackN.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 sfr_addr  out  8  address to SFR decode.
REQ-017 sfr_en, sfr_oe, sfr_Bb  out  1 each  SFR write enable, output enable, byte/bit select.
REQ-018 sfr_pos  out  8  one-hot bit position.
REQ-019 sfr_din  out  8; sfr_bin  out  1  SFR write data.
REQ-020 sfr_dout  in  8; sfr_bout  in  1  SFR read data, updated by the SFR on falling clk edge.

Function
REQ-021 FSM states IDLE, ISSUE, CAPTURE, RESP; IDLE->ISSUE on grant; ISSUE->CAPTURE; CAPTURE->RESP; RESP->IDLE unconditionally.
REQ-022 In IDLE, a sampled request is granted and its weN, BbN, addrN, posN, dataN, bitN are latched at the same edge; later changes to those inputs have no effect on the transaction.
REQ-023 Arbitration with both requests high in IDLE: PRIO_MODE=0 grants the requester not served last; PRIO_MODE=1 always grants requester 0.
REQ-024 The last-served pointer resets to 1, so requester 0 wins the first tie after reset.
REQ-025 ISSUE: drive sfr_addr, sfr_Bb, sfr_pos = 1<<pos, sfr_din, sfr_bin from the latch; sfr_en = we; sfr_oe = ~we; all for exactly one cycle.
REQ-026 CAPTURE: sfr_en = 0; sfr_oe and address held for reads; at the closing edge rdata <= sfr_dout for byte reads, rbit <= sfr_bout for bit reads, all other read fields <= 0.
REQ-027 RESP: ackN of the granted requester high for exactly one cycle, with errN, rdataN, rbitN valid; the other requester's outputs stay 0.
REQ-028 Latency: request sampled at edge k -> ackN high in cycle k+3; maximum throughput one transaction per 4 cycles.
REQ-029 addr[7]=0: FSM still runs ISSUE and CAPTURE with sfr_en = sfr_oe = 0; RESP asserts ackN with errN=1, rdataN=0, rbitN=0.
REQ-030 Dropping reqN before ackN does not abort the transaction; the ack is still issued.
REQ-031 sfr_en, sfr_oe, sfr_pos and sfr_din are 0 in IDLE, RESP and any cycle other than those stated above.

Reset
REQ-032 On a reset edge: FSM -> IDLE, last-served pointer -> 1, and all outputs -> 0 from the following cycle.
REQ-033 Reset in any state discards the transaction with no ack; a write whose ISSUE cycle had already completed is not undone.

Verification
REQ-034 Byte write: req0, we=1, Bb=1, addr=0xA8, data=0x5A -> in the ISSUE cycle sfr_en=1, sfr_din=0x5A; ack0 in k+3; err0=0.
REQ-035 Bit read: req1, we=0, Bb=0, addr=0xD0, pos=7, sfr_bout model=1 -> sfr_pos=0x80 in ISSUE; ack1 with rbit1=1, rdata1=0x00.
REQ-036 Tie, PRIO_MODE=0, both requesters held high -> grants alternate 0,1,0,1, with acks 4 cycles apart; PRIO_MODE=1 -> only requester 0 is served while req0 is held.
REQ-037 Out-of-range access: addr=0x45 write -> sfr_en never asserted; ack with err=1.
REQ-038 Reset asserted in CAPTURE -> no ack; busy=0 and all sfr_* outputs are 0 in the next cycle; a new request then completes normally.
